// File: rtl/match_referee_pkg.sv
// match_referee_pkg: shared state, winner encodings and datapath widths for the match referee
package match_referee_pkg;
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, RALLY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
   typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_ONE = 2'b01, WIN_TWO = 2'b10} winner_t;
   localparam int SCORE_W = 4;
   localparam int RALLY_W = 8;
endpackage

// File: rtl/match_referee_point_timer.sv
// point_timer: load/count-down pause timer, done asserts on the last cycle of the pause
module point_timer #(
   parameter int DELAY = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_done
);
   localparam int W = $clog2(DELAY + 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (!rst) r_cnt <= '0;
      else if (i_load) r_cnt <= W'(DELAY - 1);
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_done = i_en && r_cnt == '0;
endmodule

// File: rtl/match_referee.sv
// match_referee: serve/rally/point FSM with score keeping for tennis and squash scoring
module match_referee
   import match_referee_pkg::*;
#(
   parameter int WIN_SCORE   = 7,
   parameter int POINT_DELAY = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               return_one,
   input  logic               return_two,
   input  logic               miss_one,
   input  logic               miss_two,
   input  logic               squash_en,
   output logic               start_game,
   output logic               serve_two,
   output logic [SCORE_W-1:0] score_one,
   output logic [SCORE_W-1:0] score_two,
   output logic [RALLY_W-1:0] rally_count,
   output logic [1:0]         winner,
   output logic [2:0]         phase
);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   state_t r_state, w_next;
   winner_t r_winner;
   logic [SCORE_W-1:0] r_score_one, r_score_two;
   logic [RALLY_W-1:0] r_rally;
   logic r_serve_two, r_squash, r_hit_valid, r_hit_two;
   logic w_miss, w_start, w_to_point, w_done, w_win_one, w_win_two, w_sq_one, w_pt_one, w_pt_two;
   assign w_miss     = miss_one || miss_two;
   assign w_start    = btn_start && (r_state == IDLE || r_state == OVER);
   assign w_to_point = r_state == RALLY && w_miss;
   assign w_win_one  = r_score_one == WIN;
   assign w_win_two  = r_score_two == WIN;
   // squash: point to the last hitter, or to the server if nobody has returned yet
   assign w_sq_one   = r_hit_valid ? !r_hit_two : !r_serve_two;
   assign w_pt_one   = r_squash ? w_sq_one : (miss_two && !miss_one);
   assign w_pt_two   = r_squash ? !w_sq_one : (miss_one && !miss_two);
   point_timer #(.DELAY(POINT_DELAY)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .i_load(w_to_point),
      .i_en  (r_state == POINT),
      .o_done(w_done)
   );
   always_ff @(posedge clk)
      if (!rst) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, OVER: w_next = btn_start ? SERVE : r_state;
         SERVE:      w_next = RALLY;
         RALLY:      w_next = w_miss ? POINT : RALLY;
         POINT:      w_next = w_done ? ((w_win_one || w_win_two) ? OVER : SERVE) : POINT;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst) begin
         r_score_one <= '0;
         r_score_two <= '0;
         r_rally     <= '0;
         r_winner    <= WIN_NONE;
         r_serve_two <= 1'b0;
         r_squash    <= 1'b0;
         r_hit_valid <= 1'b0;
         r_hit_two   <= 1'b0;
      end else begin
         if (w_start) begin
            r_score_one <= '0;
            r_score_two <= '0;
            r_rally     <= '0;
            r_winner    <= WIN_NONE;
            r_serve_two <= 1'b0;
            r_squash    <= squash_en;
         end
         if (r_state == SERVE) begin
            r_rally     <= '0;
            r_hit_valid <= 1'b0;
         end
         if (r_state == RALLY && !w_miss && (return_one || return_two)) begin
            r_rally     <= &r_rally ? r_rally : r_rally + 1'b1;
            r_hit_valid <= 1'b1;
            r_hit_two   <= !return_one;
         end
         if (w_to_point) begin
            if (w_pt_one && !w_win_one) r_score_one <= r_score_one + 1'b1;
            if (w_pt_two && !w_win_two) r_score_two <= r_score_two + 1'b1;
            if (w_pt_one || w_pt_two) r_serve_two <= w_pt_one;
         end
         if (r_state == POINT && w_done && (w_win_one || w_win_two))
            r_winner <= w_win_one ? WIN_ONE : WIN_TWO;
      end
   assign start_game  = r_state == SERVE;
   assign serve_two   = r_serve_two;
   assign score_one   = r_score_one;
   assign score_two   = r_score_two;
   assign rally_count = r_rally;
   assign winner      = r_winner;
   assign phase       = r_state;
endmodule

// File: tb/tb_match_referee.sv
// tb_match_referee: directed bench for match_referee with WIN_SCORE=3, POINT_DELAY=4
module tb_match_referee;
   logic clk = 1'b0;
   logic rst, btn_start, return_one, return_two, miss_one, miss_two, squash_en;
   logic start_game, serve_two;
   logic [3:0] score_one, score_two;
   logic [7:0] rally_count;
   logic [1:0] winner;
   logic [2:0] phase;
   int checks = 0;
   int errors = 0;
   match_referee #(.WIN_SCORE(3), .POINT_DELAY(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .return_one (return_one),
      .return_two (return_two),
      .miss_one   (miss_one),
      .miss_two   (miss_two),
      .squash_en  (squash_en),
      .start_game (start_game),
      .serve_two  (serve_two),
      .score_one  (score_one),
      .score_two  (score_two),
      .rally_count(rally_count),
      .winner     (winner),
      .phase      (phase)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic b, input logic r1, input logic r2, input logic m1, input logic m2);
      btn_start = b; return_one = r1; return_two = r2; miss_one = m1; miss_two = m2;
      tick();
      btn_start = 0; return_one = 0; return_two = 0; miss_one = 0; miss_two = 0;
   endtask
   task automatic to_serve(input logic exp_serve);
      repeat (4) tick();
      chk("pause_to_serve", phase, 1);
      chk("next_server", serve_two, exp_serve);
      tick();
   endtask
   initial begin
      rst = 0; btn_start = 0; return_one = 0; return_two = 0; miss_one = 0; miss_two = 0; squash_en = 0;
      tick(); tick();
      chk("rst_phase", phase, 0);
      chk("rst_start", start_game, 0);
      chk("rst_serve", serve_two, 0);
      chk("rst_s1", score_one, 0);
      chk("rst_s2", score_two, 0);
      chk("rst_rally", rally_count, 0);
      chk("rst_winner", winner, 0);
      rst = 1;
      tick();
      chk("idle_hold", phase, 0);
      step(1, 0, 0, 0, 0);
      chk("start_pulse", start_game, 1);
      chk("serve_phase", phase, 1);
      tick();
      chk("rally_phase", phase, 2);
      chk("start_drop", start_game, 0);
      chk("first_server", serve_two, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("rally3", rally_count, 3);
      step(0, 0, 0, 1, 0);
      chk("miss1_phase", phase, 3);
      chk("miss1_s2", score_two, 1);
      chk("miss1_s1", score_one, 0);
      chk("miss1_rally", rally_count, 3);
      repeat (3) tick();
      chk("pause_hold", phase, 3);
      tick();
      chk("pause_exit", phase, 1);
      chk("serve_after_loss1", serve_two, 0);
      chk("restart_pulse", start_game, 1);
      tick();
      chk("rally_clear", rally_count, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1);
      chk("miss_prio_rally", rally_count, 1);
      chk("miss_prio_s1", score_one, 1);
      chk("miss_prio_s2", score_two, 1);
      to_serve(1);
      step(0, 0, 0, 1, 1);
      chk("let_phase", phase, 3);
      chk("let_s1", score_one, 1);
      chk("let_s2", score_two, 1);
      to_serve(1);
      step(1, 0, 0, 0, 0);
      chk("btn_ignored_rally", phase, 2);
      step(0, 0, 0, 0, 1);
      chk("s1_two", score_one, 2);
      to_serve(1);
      step(0, 0, 0, 0, 1);
      chk("s1_three", score_one, 3);
      repeat (4) tick();
      chk("over_phase", phase, 4);
      chk("over_winner", winner, 1);
      step(0, 1, 1, 0, 0);
      chk("over_ret_ignored", rally_count, 0);
      step(0, 0, 0, 1, 0);
      chk("over_miss_ignored", score_two, 1);
      chk("over_hold", phase, 4);
      squash_en = 1;
      step(1, 0, 0, 0, 0);
      squash_en = 0;
      chk("restart_phase", phase, 1);
      chk("restart_start", start_game, 1);
      chk("restart_s1", score_one, 0);
      chk("restart_s2", score_two, 0);
      chk("restart_winner", winner, 0);
      chk("restart_server", serve_two, 0);
      tick();
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("sq_last_hitter", score_two, 1);
      chk("sq_s1_zero", score_one, 0);
      to_serve(0);
      step(0, 0, 0, 0, 1);
      chk("sq_server_pt", score_one, 1);
      chk("sq_s2_keep", score_two, 1);
      step(1, 0, 0, 1, 0);
      chk("point_ignores", phase, 3);
      chk("point_miss_ignored", score_two, 1);
      rst = 0;
      tick();
      chk("abort_phase", phase, 0);
      chk("abort_start", start_game, 0);
      chk("abort_s1", score_one, 0);
      chk("abort_s2", score_two, 0);
      chk("abort_serve", serve_two, 0);
      chk("abort_rally", rally_count, 0);
      chk("abort_winner", winner, 0);
      tick();
      chk("abort_no_pulse", start_game, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/match_referee.md
MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a match (legal range 1..15).
REQ-002 Parameter POINT_DELAY, default 50_000_000, cycles of pause after each point (minimum 1).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 btn_start  in  1  debounced single-cycle start/restart pulse.
REQ-006 return_one, return_two  in  1 each  single-cycle pulse: player made a legal return.
REQ-007 miss_one, miss_two  in  1 each  single-cycle pulse: ball passed that player's end unreturned.
REQ-008 squash_en  in  1  squash mode; sampled only on the cycle IDLE or OVER exits.
REQ-009 start_game  out  1  single-cycle pulse launching a serve to ball and players.
REQ-010 serve_two  out  1  0 = player one serves, 1 = player two serves.
REQ-011 score_one, score_two  out  4 each  current points.
REQ-012 rally_count  out  8  returns in current rally, saturating at 255.
REQ-013 winner  out  2  00 none, 01 player one, 10 player two.
REQ-014 phase  out  3  current FSM state encoding.

Function
REQ-015 States: IDLE, SERVE, RALLY, POINT, OVER.
- IDLE: btn_start -> SERVE; scores, rally_count, winner cleared; latch squash_en.
- SERVE: assert start_game for exactly one cycle; next cycle -> RALLY; rally_count cleared.
- RALLY: return pulses increment rally_count and update last_hitter (return_one wins if both assert).
- POINT: hold POINT_DELAY cycles, then -> OVER if either score = WIN_SCORE, else -> SERVE.
- OVER: winner held; btn_start -> SERVE with scores/winner cleared, serve_two = 0, squash_en re-latched.
REQ-016 Tennis mode, RALLY: miss_one alone -> score_two+1; miss_two alone -> score_one+1; -> POINT.
REQ-017 Tennis mode, miss_one and miss_two same cycle: let; no score change, server unchanged, -> POINT.
REQ-018 Squash mode, RALLY: any miss pulse awards point to last_hitter; with no return yet, to the server; -> POINT.
REQ-019 Next server = loser of last point; after a let, unchanged.
REQ-020 Score updates on the transition cycle into POINT; outputs show the new value one cycle after the miss pulse.
REQ-021 Scores saturate at WIN_SCORE and never wrap.
REQ-022 winner set on the cycle POINT -> OVER, from the player at WIN_SCORE.
REQ-023 btn_start ignored in SERVE, RALLY, POINT; return/miss pulses ignored outside RALLY.
REQ-024 Miss and return asserted on the same cycle in RALLY: miss takes priority, rally_count unchanged.
REQ-025 Pause counter resets on each POINT entry; exit occurs exactly POINT_DELAY cycles after entry.

Reset
REQ-026 rst low at a rising edge: phase = IDLE, start_game = 0, serve_two = 0, scores = 0, rally_count = 0, winner = 00, last_hitter cleared, pause counter = 0, latched squash = 0.
REQ-027 Reset mid-rally or mid-pause aborts the match with no pulse on start_game.
REQ-028 Reset overrides every input on the same edge.

Structure
REQ-029 Shared package holds the state encoding, winner encoding, score width (4), and rally width (8).
REQ-030 One sub-module, point_timer: load/count-down pause timer with done pulse, width from clog2(POINT_DELAY+1).
REQ-031 All other logic is a single FSM plus score registers in match_referee.

Verification (POINT_DELAY = 4, WIN_SCORE = 3)
REQ-032 Reset then btn_start -> start_game high exactly one cycle later, phase RALLY the cycle after, serve_two = 0.
REQ-033 Tennis mode, three return pulses then miss_one -> rally_count = 3, score_two = 1, POINT for 4 cycles, then SERVE with serve_two = 0.
REQ-034 miss_one and miss_two same cycle -> scores unchanged, serve_two unchanged, POINT then SERVE.
REQ-035 Squash mode, return_two then miss_one -> score_two = 1; fresh serve by player one with no return then miss_two -> score_one = 1.
REQ-036 Player one scores 3 points -> phase OVER, winner = 01; return pulses ignored; btn_start -> scores = 0, winner = 00, start_game pulses.
REQ-037 rst low during POINT pause -> next cycle phase IDLE with all outputs at reset values, and no start_game pulse.
